// File: rtl/display_scan_mux_if.sv
// Display scan multiplexer bus: scan controls and digit data in,
// time-multiplexed digit code, index, anodes and frame pulse out.
interface display_scan_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 5
);
    localparam int SEL_W = $clog2(NUM_DIGITS);

    logic                         ENABLE;
    logic [NUM_DIGITS*DATA_W-1:0] DIGITS_IN;
    logic [NUM_DIGITS-1:0]        BLANK_MASK;
    logic                         LZ_EN;
    logic [DATA_W-1:0]            DIGIT_OUT;
    logic [SEL_W-1:0]             DIGIT_SEL;
    logic [NUM_DIGITS-1:0]        ANODE;
    logic                         FRAME_START;

    modport master (
        output ENABLE, DIGITS_IN, BLANK_MASK, LZ_EN,
        input  DIGIT_OUT, DIGIT_SEL, ANODE, FRAME_START
    );

    modport slave (
        input  ENABLE, DIGITS_IN, BLANK_MASK, LZ_EN,
        output DIGIT_OUT, DIGIT_SEL, ANODE, FRAME_START
    );
endinterface

// File: rtl/display_scan_mux.sv
// Multiplexed display scanner: prescaled digit rotation, per-frame
// input snapshot, anode guard interval and leading-zero suppression.
module display_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int DATA_W       = 5,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input logic               CLK,
    input logic               RESET,
    display_scan_mux_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int DIG_W = NUM_DIGITS * DATA_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [SEL_W-1:0]      idx, idx_n;
    logic [DIG_W-1:0]      sh_dig, sh_dig_n;
    logic [NUM_DIGITS-1:0] sh_mask, sh_mask_n;
    logic                  pend, pend_n;
    logic                  wrap;
    logic                  guard;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] dark;
    logic [DATA_W-1:0]     code_n;
    logic [NUM_DIGITS-1:0] anode_n;

    logic [DATA_W-1:0]     dout;
    logic [SEL_W-1:0]      dsel;
    logic [NUM_DIGITS-1:0] anode;
    logic                  fstart;

    // Prescaler, digit index and snapshot next-state
    always_comb begin
        cnt_n     = cnt;
        idx_n     = idx;
        sh_dig_n  = sh_dig;
        sh_mask_n = sh_mask;
        pend_n    = pend;
        wrap      = 1'b0;
        if (bus.ENABLE) begin
            if (cnt == CNT_LAST) begin
                cnt_n = '0;
                if (idx == IDX_LAST) begin
                    idx_n = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end else begin
                cnt_n = cnt + 1'b1;
            end
            if (pend || wrap) begin
                sh_dig_n  = bus.DIGITS_IN;
                sh_mask_n = bus.BLANK_MASK;
                pend_n    = 1'b0;
            end
        end
    end

    // Guard interval keeps anodes off at the start of every slot
    generate
        if (BLANK_CYCLES == 0) begin : g_noguard
            assign guard = 1'b0;
        end else begin : g_guard
            localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CYCLES);
            assign guard = (cnt_n < BLANK_V);
        end
    endgenerate

    // Dark digits: masked, or within a run of leading zeros above digit 0
    always_comb begin
        zero_run = 1'b1;
        dark     = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (sh_dig_n[k*DATA_W +: DATA_W] == '0);
            dark[k]  = sh_mask_n[k] || (bus.LZ_EN && (k > 0) && zero_run);
        end
    end

    // Code and anode pattern for the digit selected after this edge
    always_comb begin
        code_n  = '0;
        anode_n = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_n == SEL_W'(k)) begin
                code_n = sh_dig_n[k*DATA_W +: DATA_W];
                if (!guard && !dark[k]) begin
                    anode_n[k] = 1'b0;
                end
            end
        end
    end

    // Scan state and registered outputs share one edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt     <= '0;
            idx     <= '0;
            sh_dig  <= '0;
            sh_mask <= '0;
            pend    <= 1'b1;
            dout    <= '0;
            dsel    <= '0;
            anode   <= '1;
            fstart  <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            idx     <= idx_n;
            sh_dig  <= sh_dig_n;
            sh_mask <= sh_mask_n;
            pend    <= pend_n;
            if (bus.ENABLE) begin
                dout   <= code_n;
                dsel   <= idx_n;
                anode  <= anode_n;
                fstart <= wrap;
            end else begin
                anode  <= '1;
                fstart <= 1'b0;
            end
        end
    end

    assign bus.DIGIT_OUT   = dout;
    assign bus.DIGIT_SEL   = dsel;
    assign bus.ANODE       = anode;
    assign bus.FRAME_START = fstart;
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with NUM_DIGITS=4, DATA_W=5,
// PRESCALE=8, BLANK_CYCLES=2; edge e gives count e%8, slot (e/8)%4.
module tb_display_scan_mux;
    logic CLK = 1'b0;
    logic RESET;
    int   tests = 0;
    int   fails = 0;
    int   e = 0;

    display_scan_mux_if #(.NUM_DIGITS(4), .DATA_W(5)) bus ();

    display_scan_mux #(
        .NUM_DIGITS(4),
        .DATA_W(5),
        .PRESCALE(8),
        .BLANK_CYCLES(2)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go(input int target);
        while (e < target) begin
            @(negedge CLK);
            e++;
        end
    endtask

    task automatic digs(input int d3, input int d2, input int d1, input int d0);
        bus.DIGITS_IN = {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endtask

    function automatic int sel();
        return int'(bus.DIGIT_SEL);
    endfunction

    function automatic int dout();
        return int'(bus.DIGIT_OUT);
    endfunction

    function automatic int an();
        return int'(bus.ANODE);
    endfunction

    function automatic int fs();
        return int'(bus.FRAME_START);
    endfunction

    initial begin
        RESET          = 1'b1;
        bus.ENABLE     = 1'b0;
        bus.LZ_EN      = 1'b0;
        bus.BLANK_MASK = 4'b0000;
        digs(9, 8, 7, 6);
        #1;
        chk("rst_sel", sel(), 0);
        chk("rst_dout", dout(), 0);
        chk("rst_anode", an(), 15);
        chk("rst_fs", fs(), 0);

        @(negedge CLK);
        RESET      = 1'b0;
        bus.ENABLE = 1'b1;
        e = 0;

        go(1);
        chk("e1_sel", sel(), 0);
        chk("e1_dout", dout(), 6);
        chk("e1_anode", an(), 15);
        chk("e1_fs", fs(), 0);
        go(2);
        chk("e2_anode", an(), 14);
        go(7);
        chk("e7_anode", an(), 14);
        go(8);
        chk("e8_sel", sel(), 1);
        chk("e8_dout", dout(), 7);
        chk("e8_anode", an(), 15);
        go(10);
        chk("e10_anode", an(), 13);
        go(18);
        chk("e18_sel", sel(), 2);
        chk("e18_dout", dout(), 8);
        chk("e18_anode", an(), 11);
        digs(5, 8, 7, 4);
        go(26);
        chk("e26_sel", sel(), 3);
        chk("snap_d3_held", dout(), 9);
        chk("e26_anode", an(), 7);
        go(31);
        chk("e31_fs", fs(), 0);
        go(32);
        chk("e32_sel", sel(), 0);
        chk("snap_d0_new", dout(), 4);
        chk("e32_fs", fs(), 1);
        chk("e32_anode", an(), 15);
        go(33);
        chk("e33_fs", fs(), 0);
        go(34);
        chk("e34_anode", an(), 14);
        go(56);
        chk("e56_sel", sel(), 3);
        chk("snap_d3_new", dout(), 5);
        digs(9, 8, 7, 6);
        bus.BLANK_MASK = 4'b0100;

        go(64);
        chk("e64_dout", dout(), 6);
        chk("e64_fs", fs(), 1);
        go(82);
        chk("mask_sel", sel(), 2);
        chk("mask_dout", dout(), 8);
        chk("mask_anode_a", an(), 15);
        bus.BLANK_MASK = 4'b0000;
        go(87);
        chk("mask_anode_b", an(), 15);
        go(90);
        chk("e90_anode", an(), 7);
        chk("e90_dout", dout(), 9);
        digs(0, 0, 7, 0);
        bus.LZ_EN = 1'b1;

        go(98);
        chk("lz_d0_anode", an(), 14);
        chk("lz_d0_dout", dout(), 0);
        go(106);
        chk("lz_d1_anode", an(), 13);
        chk("lz_d1_dout", dout(), 7);
        go(114);
        chk("lz_d2_sel", sel(), 2);
        chk("lz_d2_anode", an(), 15);
        chk("lz_d2_dout", dout(), 0);
        go(122);
        chk("lz_d3_sel", sel(), 3);
        chk("lz_d3_anode", an(), 15);
        digs(0, 0, 0, 0);
        go(130);
        chk("lz0_d0_anode", an(), 14);
        go(138);
        chk("lz0_d1_sel", sel(), 1);
        chk("lz0_d1_anode", an(), 15);
        bus.LZ_EN = 1'b0;
        digs(9, 8, 7, 6);

        go(173);
        chk("e173_sel", sel(), 1);
        chk("e173_anode", an(), 13);
        chk("e173_dout", dout(), 7);
        bus.ENABLE = 1'b0;
        go(174);
        chk("dis_anode", an(), 15);
        chk("dis_sel", sel(), 1);
        chk("dis_fs", fs(), 0);
        go(193);
        chk("dis_hold_anode", an(), 15);
        chk("dis_hold_sel", sel(), 1);
        chk("dis_hold_dout", dout(), 7);
        bus.ENABLE = 1'b1;
        go(194);
        chk("resume_anode", an(), 13);
        go(195);
        chk("resume_last_anode", an(), 13);
        chk("resume_last_sel", sel(), 1);
        bus.ENABLE = 1'b0;
        go(196);
        chk("tickdrop_sel", sel(), 1);
        chk("tickdrop_anode", an(), 15);
        bus.ENABLE = 1'b1;
        go(197);
        chk("tickresume_sel", sel(), 2);
        chk("tickresume_dout", dout(), 8);
        chk("tickresume_anode", an(), 15);
        go(199);
        chk("e199_anode", an(), 11);
        go(207);
        chk("e207_sel", sel(), 3);
        chk("e207_anode", an(), 7);
        chk("e207_dout", dout(), 9);

        #2;
        RESET = 1'b1;
        #1;
        chk("async_sel", sel(), 0);
        chk("async_dout", dout(), 0);
        chk("async_anode", an(), 15);
        chk("async_fs", fs(), 0);
        @(negedge CLK);
        chk("held_rst_anode", an(), 15);
        RESET = 1'b0;
        e = 0;
        go(1);
        chk("rs1_sel", sel(), 0);
        chk("rs1_dout", dout(), 6);
        chk("rs1_anode", an(), 15);
        chk("rs1_fs", fs(), 0);
        go(2);
        chk("rs2_anode", an(), 14);
        go(8);
        chk("rs8_sel", sel(), 1);
        go(32);
        chk("rs32_sel", sel(), 0);
        chk("rs32_fs", fs(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 The block SHALL take these parameters:
- NUM_DIGITS, default 4: digit count, legal range 2..8.
- DATA_W, default 5: bits per digit code.
- PRESCALE, default 50000: clock cycles per digit slot, legal range >= 2.
- BLANK_CYCLES, default 16: anode-off guard at start of each slot; must be < PRESCALE.
REQ-002 The block SHALL have one clock and asynchronous active-high reset, with these ports (clock and reset first):
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high.
- ENABLE  in  1  scan enable.
- DIGITS_IN  in  NUM_DIGITS*DATA_W  digit k at bits [k*DATA_W +: DATA_W].
- BLANK_MASK  in  NUM_DIGITS  1 = force digit k dark.
- LZ_EN  in  1  leading-zero suppression enable.
- DIGIT_OUT  out  DATA_W  code of the current digit, to the segment decoder.
- DIGIT_SEL  out  clog2(NUM_DIGITS)  current digit index.
- ANODE  out  NUM_DIGITS  active-low one-hot digit enable.
- FRAME_START  out  1  one-cycle pulse when the index wraps to 0.

Function
REQ-003 A prescaler SHALL count 0..PRESCALE-1 while ENABLE=1 and wrap to 0; "tick" = the cycle in which the count equals PRESCALE-1.
REQ-004 On each tick the digit index SHALL advance by 1 modulo NUM_DIGITS (wrap NUM_DIGITS-1 -> 0).
REQ-005 Shadow registers for DIGITS_IN and BLANK_MASK SHALL load on the first enabled cycle after reset and on every tick that wraps the index to 0; between loads, input changes SHALL have no effect on outputs.
REQ-006 DIGIT_SEL, DIGIT_OUT and ANODE SHALL be registered and SHALL update on the same clock edge as the index, so they are always mutually consistent.
REQ-007 Prescaler count < BLANK_CYCLES -> ANODE SHALL be all ones. Otherwise, bit [index] SHALL be 0 unless that digit is dark. BLANK_CYCLES=0 means no guard interval.
REQ-008 Digit k SHALL be dark if shadow BLANK_MASK[k]=1, or if LZ_EN=1, k>0 and shadow digits k..NUM_DIGITS-1 all equal zero.
REQ-009 Digit 0 SHALL never be suppressed by LZ_EN; a shadow value of all zeros displays as a single digit.
REQ-010 DIGIT_OUT SHALL equal the shadow code of the current index, including for dark digits (only the anode is gated).
REQ-011 FRAME_START SHALL be 1 for exactly the one cycle following the edge on which the index becomes 0 via wrap; it SHALL NOT pulse on reset release.
REQ-012 ENABLE=0 -> prescaler, index and shadow SHALL hold, ANODE SHALL be all ones from the next edge, and FRAME_START SHALL be 0. ENABLE returning to 1 SHALL resume from the held count.
REQ-013 Simultaneous tick and ENABLE falling: ENABLE dominates and no advance occurs.

Reset
REQ-014 RESET=1 SHALL immediately, without a clock edge, force: prescaler=0, index=0, DIGIT_SEL=0, DIGIT_OUT=0, ANODE all ones, FRAME_START=0, shadow=0, and shadow-load-pending set.
REQ-015 Reset asserted mid-slot or mid-frame SHALL abandon the scan. After release, scanning SHALL restart at digit 0 with a full guard interval.

Verification
Bench parameters: NUM_DIGITS=4, DATA_W=5, PRESCALE=8, BLANK_CYCLES=2.
REQ-016 Basic scan: ENABLE=1, LZ_EN=0, BLANK_MASK=0, digits{3,2,1,0}={9,8,7,6} -> DIGIT_SEL 0,1,2,3,0 every 8 cycles; DIGIT_OUT 6,7,8,9; ANODE 1111 for 2 cycles then 1110/1101/1011/0111 for 6; FRAME_START every 32 cycles.
REQ-017 Snapshot: change digit 0 from 6 to 4 while DIGIT_SEL=2 -> DIGIT_OUT shows 6 until after the next FRAME_START, then 4.
REQ-018 Suppression: digits{3..0}={0,0,7,0}, LZ_EN=1 -> ANODE never 0111 or 1011; 1101 and 1110 asserted; with all digits 0, only 1110 asserted.
REQ-019 Blank mask: BLANK_MASK=0100 -> ANODE stays 1111 throughout slot 2 while DIGIT_SEL=2 and DIGIT_OUT=8.
REQ-020 Enable/reset: drop ENABLE for 20 cycles at prescaler=5, DIGIT_SEL=1 -> ANODE 1111 and DIGIT_SEL=1 held, resumes with 2 cycles left in the slot; pulse RESET asynchronously mid-slot 3 -> outputs go to reset values before the next edge and the scan restarts at digit 0.
